// File: rtl/polo_pkg.sv
// polo_pkg: shared definitions for the MARCO/POLO link.
// The reply is "POLO"; defining POLO_CRLF_EN appends CR LF to it.
// The comparator side uses the same ASCII constants.
package polo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   localparam logic [7:0] ASCII_P  = 8'h50;
   localparam logic [7:0] ASCII_O  = 8'h4F;
   localparam logic [7:0] ASCII_L  = 8'h4C;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

`ifdef POLO_CRLF_EN
   localparam int MSG_LEN = 6;
`else
   localparam int MSG_LEN = 4;
`endif

   localparam int MSG_IDX_W = $clog2(MSG_LEN);

   // Byte idx of the reply; out-of-range indices return idle-line ones.
   function automatic logic [7:0] msg_byte(input logic [MSG_IDX_W-1:0] idx);
      logic [7:0] b;
      case (int'(idx))
         0:       b = ASCII_P;
         1:       b = ASCII_O;
         2:       b = ASCII_L;
         3:       b = ASCII_O;
`ifdef POLO_CRLF_EN
         4:       b = ASCII_CR;
         5:       b = ASCII_LF;
`endif
         default: b = 8'hFF;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/polo_transmitter_uart_tx_byte.sv
// uart_tx_byte: baud timing and 8N1 framing of one byte.
// State table:
//   state    | meaning
//   ST_IDLE  | line high, waiting for start
//   ST_START | driving the start bit (0)
//   ST_DATA  | driving data bits, LSB first
//   ST_STOP  | driving the stop bit (1); a start in its last cycle chains the next byte
// byte_done marks the last cycle of the stop bit, so the caller can hand
// over the next byte on that same edge and get a gapless stream.
module uart_tx_byte
   import polo_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       byte_done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_rate
      $error("uart_tx_byte: CLKS_PER_BIT must be at least 2");
   end

   tx_state_t        state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic             bit_end;

   // End of the current bit period and end of the whole frame.
   always_comb begin
      bit_end   = (baud_cnt == CNT_LAST);
      byte_done = (state == ST_STOP) && bit_end;
   end

   // Framing state machine; tx is registered straight out of here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               baud_cnt <= '0;
               if (start) begin
                  state <= ST_START;
                  shift <= data;
                  tx    <= 1'b0;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  state    <= ST_DATA;
                  bit_idx  <= '0;
                  tx       <= shift[0];
                  shift    <= {1'b1, shift[7:1]};
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state   <= ST_STOP;
                     bit_idx <= '0;
                     tx      <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shift[0];
                     shift   <= {1'b1, shift[7:1]};
                  end
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (start) begin
                     state <= ST_START;
                     shift <= data;
                     tx    <= 1'b0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/polo_transmitter.sv
// polo_transmitter: sends the "POLO" reply on a UART line after a match pulse.
// Define POLO_CRLF_EN to append CR LF to the reply.
// Matches arriving while a reply is in flight are dropped.
module polo_transmitter
   import polo_pkg::*;
#(
   parameter int CLK_FREQ = 12_000_000,
   parameter int BAUD     = 9600
) (
   input  logic clk,
   input  logic rst_n,
   input  logic match,
   output logic tx,
   output logic busy,
   output logic done
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

   logic [MSG_IDX_W-1:0] byte_idx;
   logic [MSG_IDX_W-1:0] next_idx;
   logic                 last_byte;
   logic                 byte_start;
   logic                 byte_done;
   logic [7:0]           byte_data;

   // Pick the byte to hand over: the first one on a fresh match, else the next one.
   always_comb begin
      next_idx   = byte_idx + MSG_IDX_W'(1);
      last_byte  = (byte_idx == MSG_IDX_W'(MSG_LEN - 1));
      byte_start = (!busy && match) || (byte_done && !last_byte);
      byte_data  = busy ? msg_byte(next_idx) : msg_byte('0);
   end

   // Message sequencing with busy/done status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!busy && match) begin
            busy     <= 1'b1;
            byte_idx <= '0;
         end else if (byte_done) begin
            if (last_byte) begin
               busy     <= 1'b0;
               done     <= 1'b1;
               byte_idx <= '0;
            end else begin
               byte_idx <= next_idx;
            end
         end
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx_byte (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (byte_start),
      .data      (byte_data),
      .tx        (tx),
      .byte_done (byte_done)
   );

endmodule

// File: tb/tb_polo_transmitter.sv
// Bench for polo_transmitter: a driver fires match pulses (directed and random),
// a reference model queues the expected bytes and done cycles, and a line
// monitor decodes tx mid-bit and checks busy/done against the model windows.
module tb_polo_transmitter;

   localparam int CLK_FREQ = 12_000_000;
   localparam int BAUD     = 1_200_000;
   localparam int CPB      = 10;
`ifdef POLO_CRLF_EN
   localparam int N_BYTES  = 6;
`else
   localparam int N_BYTES  = 4;
`endif
   localparam int REPLY_CYC = N_BYTES * 10 * CPB;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic match = 1'b0;
   logic tx, busy, done;

   polo_transmitter #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .match (match),
      .tx    (tx),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   logic [7:0] ref_msg [$];
   logic [7:0] exp_q   [$];
   int         done_q  [$];
   int         model_start = 0;
   int         model_end   = 0;
   int         n_decoded   = 0;

   task automatic check(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
      end
   endtask

   // Raise match now (just after an edge) for one cycle; the model accepts it only when idle.
   task automatic pulse();
      match = 1'b1;
      if (cyc >= model_end) begin
         model_start = cyc + 1;
         model_end   = model_start + REPLY_CYC;
         foreach (ref_msg[i]) exp_q.push_back(ref_msg[i]);
         done_q.push_back(model_end);
      end
      @(posedge clk); #2;
      match = 1'b0;
   endtask

   task automatic fire();
      @(posedge clk); #2;
      pulse();
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < REPLY_CYC + 50 && !seen; i++) begin
         @(posedge clk); #2;
         if (done) seen = 1'b1;
      end
      check(seen, "done_timeout", int'(seen), 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_start = 0;
      model_end   = 0;
      exp_q.delete();
      done_q.delete();
      #1;
      check(tx == 1'b1, "rst_tx", int'(tx), 1);
      check(busy == 1'b0, "rst_busy", int'(busy), 0);
      check(done == 1'b0, "rst_done", int'(done), 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   // Line monitor and status checker, sampling on the falling edge.
   bit         rx_active = 1'b0;
   int         rx_n      = 0;
   logic [7:0] rx_byte   = '0;
   bit         exp_busy;
   int         exp_val;
   always @(negedge clk) begin
      if (!rst_n) begin
         rx_active = 1'b0;
      end else begin
         exp_busy = (cyc >= model_start) && (cyc < model_end);
         check(busy == exp_busy, "busy", int'(busy), int'(exp_busy));
         if (!exp_busy) check(tx == 1'b1, "tx_idle", int'(tx), 1);
         if (done) begin
            if (done_q.size() == 0) check(1'b0, "done_unexpected", cyc, -1);
            else begin
               exp_val = done_q.pop_front();
               check(cyc == exp_val, "done_cycle", cyc, exp_val);
            end
         end
         if (!rx_active) begin
            if (tx == 1'b0) begin
               rx_active = 1'b1;
               rx_n      = 0;
            end
         end else begin
            rx_n++;
            if (rx_n == 5) check(tx == 1'b0, "start_bit", int'(tx), 0);
            if (rx_n >= 15 && rx_n <= 85 && (rx_n % 10) == 5)
               rx_byte[(rx_n - 15) / 10] = tx;
            if (rx_n == 95) begin
               check(tx == 1'b1, "stop_bit", int'(tx), 1);
               n_decoded++;
               if (exp_q.size() == 0) check(1'b0, "byte_unexpected", int'(rx_byte), -1);
               else begin
                  exp_val = int'(exp_q.pop_front());
                  check(int'(rx_byte) == exp_val, "byte", int'(rx_byte), exp_val);
               end
               rx_active = 1'b0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int gap;
      ref_msg = '{8'h50, 8'h4F, 8'h4C, 8'h4F};
`ifdef POLO_CRLF_EN
      ref_msg.push_back(8'h0D);
      ref_msg.push_back(8'h0A);
`endif
      rst_n = 1'b0;
      match = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check(tx == 1'b1, "por_tx", int'(tx), 1);
      check(busy == 1'b0, "por_busy", int'(busy), 0);
      check(done == 1'b0, "por_done", int'(done), 0);
      #1 rst_n = 1'b1;
      repeat (100) @(posedge clk);

      // single reply
      fire();
      check(tx == 1'b0, "first_start_bit", int'(tx), 0);
      wait_done();
      repeat (20) @(posedge clk);

      // match while busy is dropped
      fire();
      repeat (148) @(posedge clk);
      fire();
      wait_done();
      repeat (20) @(posedge clk);

      // back-to-back: match in the done cycle
      fire();
      wait_done();
      pulse();
      wait_done();
      repeat (20) @(posedge clk);

      // reset in the middle of the third byte
      fire();
      repeat (249) @(posedge clk);
      #2;
      do_reset();
      repeat (10) @(posedge clk);
      fire();
      wait_done();

      // random triggers, some landing while busy
      for (int k = 0; k < 8; k++) begin
         fire();
         gap = $urandom_range(REPLY_CYC + 60, 20);
         repeat (gap) @(posedge clk);
      end

      repeat (REPLY_CYC + 50) @(posedge clk);
      check(exp_q.size() == 0, "bytes_pending", exp_q.size(), 0);
      check(done_q.size() == 0, "done_pending", done_q.size(), 0);
      check(n_decoded >= 5 * N_BYTES, "bytes_decoded", n_decoded, 5 * N_BYTES);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
